// File: rtl/pu_msp430_inst_encoder_pkg.sv
// Shared types, encoding constants and helpers for the MSP430 instruction encoder.
// Both the packer and the handshake/FSM top import these.
package pu_msp430_inst_encoder_pkg;

  typedef enum logic [1:0] {
    CLS_SIG  = 2'd0,
    CLS_JUMP = 2'd1,
    CLS_TWO  = 2'd2,
    CLS_ILL  = 2'd3
  } cls_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_OPW  = 3'd1,
    ST_SEXT = 3'd2,
    ST_DEXT = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  localparam logic [5:0] SIG_PREFIX  = 6'b000100;
  localparam logic [2:0] JUMP_PREFIX = 3'b001;
  localparam logic [2:0] SIG_OP_RETI = 3'd6;

  // Indexed/symbolic/absolute use a word unless r3 makes it a constant; #N only via r0.
  function automatic logic need_src_ext(input logic [1:0] cls,
                                        input logic [1:0] as_mode,
                                        input logic [3:0] src);
    logic res;
    res = 1'b0;
    if (cls != CLS_JUMP) begin
      res = ((as_mode == 2'b01) && (src != 4'd3)) ||
            ((as_mode == 2'b11) && (src == 4'd0));
    end
    return res;
  endfunction

  function automatic logic need_dst_ext(input logic [1:0] cls,
                                        input logic       ad);
    return (cls == CLS_TWO) && ad;
  endfunction

  function automatic logic desc_illegal(input logic [1:0] cls,
                                        input logic [3:0] op);
    logic res;
    res = 1'b0;
    case (cls)
      CLS_TWO:  res = (op < 4'd4);
      CLS_SIG:  res = (op > 4'd6);
      CLS_JUMP: res = op[3];
      default:  res = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pu_msp430_inst_pack.sv
// Combinational packer: turns a latched descriptor into the opcode word and
// reports which extension words follow it.
module pu_msp430_inst_pack
  import pu_msp430_inst_encoder_pkg::*;
(
  input  logic [1:0]  cls,
  input  logic [3:0]  op,
  input  logic        bw,
  input  logic [3:0]  src,
  input  logic [1:0]  as_mode,
  input  logic [3:0]  dst,
  input  logic        ad,
  input  logic [9:0]  joff,
  output logic [15:0] opcode,
  output logic        src_ext_en,
  output logic        dst_ext_en,
  output logic        illegal
);

  logic       eff_bw;
  logic [1:0] eff_as;
  logic [3:0] eff_src;

  // RETI carries no operand, so its operand fields are zeroed before both
  // encoding and the extension decision.
  always_comb begin
    eff_bw  = bw;
    eff_as  = as_mode;
    eff_src = src;
    if ((cls == CLS_SIG) && (op[2:0] == SIG_OP_RETI)) begin
      eff_bw  = 1'b0;
      eff_as  = 2'b00;
      eff_src = 4'd0;
    end

    case (cls)
      CLS_TWO:  opcode = {op, src, ad, bw, as_mode, dst};
      CLS_SIG:  opcode = {SIG_PREFIX, op[2:0], eff_bw, eff_as, eff_src};
      CLS_JUMP: opcode = {JUMP_PREFIX, op[2:0], joff};
      default:  opcode = 16'h0000;
    endcase

    src_ext_en = need_src_ext(cls, eff_as, eff_src);
    dst_ext_en = need_dst_ext(cls, ad);
    illegal    = desc_illegal(cls, op);
  end

endmodule

// File: rtl/pu_msp430_inst_encoder.sv
// MSP430 instruction encoder: accepts a descriptor and writes opcode plus
// extension words into sequential program-memory locations.
module pu_msp430_inst_encoder
  import pu_msp430_inst_encoder_pkg::*;
#(
  parameter int unsigned          PMEM_AW    = 11,
  parameter logic [PMEM_AW-1:0]   START_ADDR = '0
) (
  input  logic               mclk,
  input  logic               puc_rst,
  input  logic               desc_valid,
  output logic               desc_ready,
  input  logic [1:0]         desc_class,
  input  logic [3:0]         desc_op,
  input  logic               desc_bw,
  input  logic [3:0]         desc_src,
  input  logic [1:0]         desc_as,
  input  logic [3:0]         desc_dst,
  input  logic               desc_ad,
  input  logic [15:0]        desc_src_ext,
  input  logic [15:0]        desc_dst_ext,
  input  logic [9:0]         desc_joff,
  input  logic               restart,
  output logic               pmem_wen,
  output logic [PMEM_AW-1:0] pmem_addr,
  output logic [15:0]        pmem_din,
  output logic               done,
  output logic               err,
  output logic [31:0]        words_total
);

  state_e             state, next_state;
  logic [PMEM_AW-1:0] addr;
  logic [1:0]         cls_q;
  logic [3:0]         op_q;
  logic               bw_q;
  logic [3:0]         src_q;
  logic [1:0]         as_q;
  logic [3:0]         dst_q;
  logic               ad_q;
  logic [15:0]        src_ext_q;
  logic [15:0]        dst_ext_q;
  logic [9:0]         joff_q;
  logic [15:0]        opcode;
  logic               src_ext_en;
  logic               dst_ext_en;
  logic               illegal_q;
  logic               accept;

  pu_msp430_inst_pack u_pack (
    .cls        (cls_q),
    .op         (op_q),
    .bw         (bw_q),
    .src        (src_q),
    .as_mode    (as_q),
    .dst        (dst_q),
    .ad         (ad_q),
    .joff       (joff_q),
    .opcode     (opcode),
    .src_ext_en (src_ext_en),
    .dst_ext_en (dst_ext_en),
    .illegal    (illegal_q)
  );

  assign desc_ready = (state == ST_IDLE) && !restart;
  assign accept     = desc_valid && desc_ready;

  // Legality is judged on the live fields at accept; the packer's flag is
  // only consulted for the latched copy and is otherwise informational.
  always_comb begin
    next_state = state;
    pmem_wen   = 1'b0;
    pmem_din   = 16'h0000;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          next_state = desc_illegal(desc_class, desc_op) ? ST_ERR : ST_OPW;
        end
      end
      ST_OPW: begin
        pmem_wen = 1'b1;
        pmem_din = opcode;
        if (src_ext_en) begin
          next_state = ST_SEXT;
        end else if (dst_ext_en) begin
          next_state = ST_DEXT;
        end else begin
          next_state = ST_IDLE;
          done       = 1'b1;
        end
      end
      ST_SEXT: begin
        pmem_wen = 1'b1;
        pmem_din = src_ext_q;
        if (dst_ext_en) begin
          next_state = ST_DEXT;
        end else begin
          next_state = ST_IDLE;
          done       = 1'b1;
        end
      end
      ST_DEXT: begin
        pmem_wen   = 1'b1;
        pmem_din   = dst_ext_q;
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      ST_ERR: begin
        err        = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign pmem_addr = addr;

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state       <= ST_IDLE;
      addr        <= START_ADDR;
      words_total <= 32'd0;
      cls_q       <= 2'd0;
      op_q        <= 4'd0;
      bw_q        <= 1'b0;
      src_q       <= 4'd0;
      as_q        <= 2'd0;
      dst_q       <= 4'd0;
      ad_q        <= 1'b0;
      src_ext_q   <= 16'h0000;
      dst_ext_q   <= 16'h0000;
      joff_q      <= 10'd0;
    end else begin
      state <= next_state;
      if ((state == ST_IDLE) && restart) begin
        addr <= START_ADDR;
      end else if (pmem_wen) begin
        addr <= addr + PMEM_AW'(1);
      end
      if (pmem_wen) begin
        words_total <= words_total + 32'd1;
      end
      if (accept) begin
        cls_q     <= desc_class;
        op_q      <= desc_op;
        bw_q      <= desc_bw;
        src_q     <= desc_src;
        as_q      <= desc_as;
        dst_q     <= desc_dst;
        ad_q      <= desc_ad;
        src_ext_q <= desc_src_ext;
        dst_ext_q <= desc_dst_ext;
        joff_q    <= desc_joff;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = illegal_q;

endmodule

// File: tb/tb_pu_msp430_inst_encoder.sv
// Directed self-checking bench for the MSP430 instruction encoder, with a
// second small-address instance for wrap and restart behaviour.
module tb_pu_msp430_inst_encoder;

  logic        mclk;
  logic        puc_rst;
  logic        desc_valid;
  logic [1:0]  desc_class;
  logic [3:0]  desc_op;
  logic        desc_bw;
  logic [3:0]  desc_src;
  logic [1:0]  desc_as;
  logic [3:0]  desc_dst;
  logic        desc_ad;
  logic [15:0] desc_src_ext;
  logic [15:0] desc_dst_ext;
  logic [9:0]  desc_joff;
  logic        restart;

  logic        desc_ready, pmem_wen, done, err;
  logic [10:0] pmem_addr;
  logic [15:0] pmem_din;
  logic [31:0] words_total;

  logic        s_ready, s_wen, s_done, s_err;
  logic [3:0]  s_addr;
  logic [15:0] s_din;
  logic [31:0] s_total;

  int errCount;
  int checkCount;
  logic [10:0] expAddr;
  logic [31:0] expTotal;

  pu_msp430_inst_encoder dut (
    .mclk(mclk), .puc_rst(puc_rst), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_class(desc_class), .desc_op(desc_op), .desc_bw(desc_bw), .desc_src(desc_src),
    .desc_as(desc_as), .desc_dst(desc_dst), .desc_ad(desc_ad),
    .desc_src_ext(desc_src_ext), .desc_dst_ext(desc_dst_ext), .desc_joff(desc_joff),
    .restart(restart), .pmem_wen(pmem_wen), .pmem_addr(pmem_addr), .pmem_din(pmem_din),
    .done(done), .err(err), .words_total(words_total)
  );

  pu_msp430_inst_encoder #(.PMEM_AW(4), .START_ADDR(4'hE)) dut_s (
    .mclk(mclk), .puc_rst(puc_rst), .desc_valid(desc_valid), .desc_ready(s_ready),
    .desc_class(desc_class), .desc_op(desc_op), .desc_bw(desc_bw), .desc_src(desc_src),
    .desc_as(desc_as), .desc_dst(desc_dst), .desc_ad(desc_ad),
    .desc_src_ext(desc_src_ext), .desc_dst_ext(desc_dst_ext), .desc_joff(desc_joff),
    .restart(restart), .pmem_wen(s_wen), .pmem_addr(s_addr), .pmem_din(s_din),
    .done(s_done), .err(s_err), .words_total(s_total)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] cls, input logic [3:0] op,
                               input logic bw, input logic [3:0] src,
                               input logic [1:0] as_mode, input logic [3:0] dst,
                               input logic ad, input logic [15:0] sext,
                               input logic [15:0] dext, input logic [9:0] joff);
    desc_class   = cls;
    desc_op      = op;
    desc_bw      = bw;
    desc_src     = src;
    desc_as      = as_mode;
    desc_dst     = dst;
    desc_ad      = ad;
    desc_src_ext = sext;
    desc_dst_ext = dext;
    desc_joff    = joff;
    desc_valid   = 1'b1;
    #1;
    checkOutput("ready_at_accept", desc_ready, 1);
    step();
    desc_valid = 1'b0;
  endtask

  task automatic expectWrite(input string tag, input logic [15:0] data, input logic last);
    checkOutput({tag, "_wen"}, pmem_wen, 1);
    checkOutput({tag, "_addr"}, pmem_addr, expAddr);
    checkOutput({tag, "_din"}, pmem_din, data);
    checkOutput({tag, "_done"}, done, last);
    checkOutput({tag, "_err"}, err, 0);
    step();
    expAddr  = expAddr + 11'd1;
    expTotal = expTotal + 32'd1;
  endtask

  task automatic expectIllegal(input string tag);
    checkOutput({tag, "_err"}, err, 1);
    checkOutput({tag, "_wen"}, pmem_wen, 0);
    checkOutput({tag, "_addr"}, pmem_addr, expAddr);
    step();
    checkOutput({tag, "_err_clr"}, err, 0);
    checkOutput({tag, "_ready"}, desc_ready, 1);
  endtask

  initial begin
    errCount = 0;
    checkCount = 0;
    puc_rst = 1'b1;
    restart = 1'b0;
    desc_valid = 1'b0;
    desc_class = 2'd0; desc_op = 4'd0; desc_bw = 1'b0; desc_src = 4'd0;
    desc_as = 2'd0; desc_dst = 4'd0; desc_ad = 1'b0;
    desc_src_ext = 16'h0; desc_dst_ext = 16'h0; desc_joff = 10'd0;
    step();
    step();
    checkOutput("rst_wen", pmem_wen, 0);
    checkOutput("rst_din", pmem_din, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_total", words_total, 0);
    checkOutput("rst_addr", pmem_addr, 0);
    checkOutput("rst_s_addr", s_addr, 4'hE);
    puc_rst = 1'b0;
    expAddr = 11'd0;
    expTotal = 32'd0;
    #1;
    checkOutput("rst_ready", desc_ready, 1);

    // MOV r4,r5
    applyStimulus(2'd2, 4'd4, 0, 4'd4, 2'd0, 4'd5, 0, 16'h0, 16'h0, 10'd0);
    expectWrite("mov_rr", 16'h4405, 1);
    checkOutput("mov_rr_total", words_total, 1);
    checkOutput("mov_rr_idle_wen", pmem_wen, 0);

    // MOV #0x1234,&0x0200
    applyStimulus(2'd2, 4'd4, 0, 4'd0, 2'd3, 4'd2, 1, 16'h1234, 16'h0200, 10'd0);
    expectWrite("mov_imm_op", 16'h40B2, 0);
    expectWrite("mov_imm_sx", 16'h1234, 0);
    expectWrite("mov_imm_dx", 16'h0200, 1);
    checkOutput("mov_imm_ready", desc_ready, 1);
    checkOutput("mov_imm_total", words_total, expTotal);

    // JMP -1, PUSH.B @r6+, CALL #0xF000
    applyStimulus(2'd1, 4'd7, 0, 4'd0, 2'd0, 4'd0, 0, 16'h0, 16'h0, 10'h3FF);
    expectWrite("jmp", 16'h3FFF, 1);
    applyStimulus(2'd0, 4'd4, 1, 4'd6, 2'd3, 4'd0, 0, 16'h0, 16'h0, 10'd0);
    expectWrite("push_b", 16'h1276, 1);
    applyStimulus(2'd0, 4'd5, 0, 4'd0, 2'd3, 4'd0, 0, 16'hF000, 16'h0, 10'd0);
    expectWrite("call_op", 16'h12B0, 0);
    expectWrite("call_sx", 16'hF000, 1);

    // RETI with junk operand fields, and a constant-generator source (no ext)
    applyStimulus(2'd0, 4'd6, 1, 4'd5, 2'd1, 4'd0, 0, 16'hBEEF, 16'h0, 10'd0);
    expectWrite("reti", 16'h1300, 1);
    applyStimulus(2'd2, 4'd4, 0, 4'd3, 2'd1, 4'd7, 0, 16'hBEEF, 16'h0, 10'd0);
    expectWrite("mov_cg", 16'h4317, 1);
    checkOutput("cg_no_ext_wen", pmem_wen, 0);
    checkOutput("cg_total", words_total, expTotal);

    // Illegal descriptors
    applyStimulus(2'd2, 4'd2, 0, 4'd4, 2'd0, 4'd5, 0, 16'h0, 16'h0, 10'd0);
    expectIllegal("ill_two");
    applyStimulus(2'd0, 4'd7, 0, 4'd4, 2'd0, 4'd0, 0, 16'h0, 16'h0, 10'd0);
    expectIllegal("ill_sig");
    applyStimulus(2'd3, 4'd4, 0, 4'd4, 2'd0, 4'd5, 0, 16'h0, 16'h0, 10'd0);
    expectIllegal("ill_cls");
    applyStimulus(2'd1, 4'd8, 0, 4'd0, 2'd0, 4'd0, 0, 16'h0, 16'h0, 10'd0);
    expectIllegal("ill_jmp");
    checkOutput("ill_total", words_total, expTotal);
    applyStimulus(2'd2, 4'd4, 0, 4'd4, 2'd0, 4'd5, 0, 16'h0, 16'h0, 10'd0);
    expectWrite("after_ill", 16'h4405, 1);

    // Small instance: wrap from 0xF to 0x0
    puc_rst = 1'b1;
    step();
    puc_rst = 1'b0;
    expAddr = 11'd0;
    expTotal = 32'd0;
    applyStimulus(2'd2, 4'd4, 0, 4'd0, 2'd3, 4'd2, 1, 16'h1234, 16'h0200, 10'd0);
    checkOutput("wrap_a0", s_addr, 4'hE);
    checkOutput("wrap_w0", s_wen, 1);
    expectWrite("wrap_op", 16'h40B2, 0);
    checkOutput("wrap_a1", s_addr, 4'hF);
    expectWrite("wrap_sx", 16'h1234, 0);
    checkOutput("wrap_a2", s_addr, 4'h0);
    checkOutput("wrap_done", s_done, 1);
    expectWrite("wrap_dx", 16'h0200, 1);
    checkOutput("wrap_a3", s_addr, 4'h1);

    // restart beats desc_valid in the same cycle
    restart = 1'b1;
    desc_valid = 1'b1;
    #1;
    checkOutput("restart_ready", desc_ready, 0);
    step();
    restart = 1'b0;
    desc_valid = 1'b0;
    checkOutput("restart_no_wen", pmem_wen, 0);
    checkOutput("restart_s_addr", s_addr, 4'hE);
    checkOutput("restart_addr", pmem_addr, 0);
    checkOutput("restart_total", words_total, 3);
    step();
    checkOutput("restart_still_idle", pmem_wen, 0);

    // Reset during SEXT of a three-word instruction
    expAddr = 11'd0;
    applyStimulus(2'd2, 4'd4, 0, 4'd0, 2'd3, 4'd2, 1, 16'h5555, 16'hAAAA, 10'd0);
    expectWrite("abort_op", 16'h40B2, 0);
    checkOutput("abort_sx_wen", pmem_wen, 1);
    checkOutput("abort_sx_din", pmem_din, 16'h5555);
    puc_rst = 1'b1;
    step();
    puc_rst = 1'b0;
    checkOutput("abort_wen", pmem_wen, 0);
    checkOutput("abort_addr", pmem_addr, 0);
    checkOutput("abort_total", words_total, 0);
    checkOutput("abort_ready", desc_ready, 1);
    step();
    checkOutput("abort_no_dext", pmem_wen, 0);
    checkOutput("abort_addr2", pmem_addr, 0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pu_msp430_inst_encoder.md
Name: pu_msp430_inst_encoder

Overview:
Testbench-side MSP430 instruction encoder, the inverse of the instruction-decode debug monitor. It accepts an instruction descriptor (class, operation, registers, addressing modes, extension words) over a valid/ready handshake. It emits the encoded opcode word plus any source and destination extension words as sequential writes into program memory. Used to build directed instruction streams for core tests without an external assembler.

Parameters:
PMEM_AW, 11, program-memory word-address width
START_ADDR, 0, word address loaded on reset and on restart

Ports:
mclk  in  1  main system clock
puc_rst  in  1  main system reset; synchronous, active-high
desc_valid  in  1  descriptor valid
desc_ready  out  1  encoder can accept a descriptor
desc_class  in  2  0=SIG-OP, 1=JUMP, 2=TWO-OP, 3=illegal
desc_op  in  4  TWO-OP opcode 4..15 (MOV..AND); SIG-OP 0..6 (RRC..RETI); JUMP condition 0..7 (JNE..JMP)
desc_bw  in  1  byte mode (.B)
desc_src  in  4  source register (SIG-OP operand register)
desc_as  in  2  source addressing mode
desc_dst  in  4  destination register
desc_ad  in  1  destination addressing mode
desc_src_ext  in  16  source extension word
desc_dst_ext  in  16  destination extension word
desc_joff  in  10  jump word offset, two's complement
restart  in  1  reload write address to START_ADDR
pmem_wen  out  1  program-memory write enable
pmem_addr  out  PMEM_AW  write word address
pmem_din  out  16  write data
done  out  1  pulse: last word of the instruction written
err  out  1  pulse: illegal descriptor rejected
words_total  out  32  total words written since reset

Behaviour:
- One clock, mclk. puc_rst is synchronous and active-high.
- Reset values: state IDLE; address START_ADDR; pmem_wen=0, pmem_din=0, done=0, err=0, words_total=0.
- Reset asserted mid-instruction aborts the instruction: no further writes occur and the remaining words are discarded.
- FSM states: IDLE, OPW, SEXT, DEXT, ERR.
- desc_ready = (state==IDLE) & ~restart.
  - restart in IDLE loads START_ADDR and has priority over desc_valid.
  - restart in any other state is ignored.
- Accept: desc_valid & desc_ready.
  - All descriptor fields are latched on accept.
  - Next state is OPW if the descriptor is legal, else ERR.
- Legality:
  - class 3 is illegal.
  - TWO-OP with op<4 is illegal.
  - SIG-OP with op>6 is illegal.
  - JUMP with op[3]=1 is illegal.
- Encoding:
  - TWO-OP = {op, src, ad, bw, as, dst}.
  - SIG-OP = {6'b000100, op[2:0], bw, as, src}. For RETI (op 6), bw, as and src are forced to 0.
  - JUMP = {3'b001, op[2:0], joff}.
- Source extension is needed when either holds:
  - as==01 and src!=3 (covers x(Rn), EDE and &EDE);
  - as==11 and src==0 (#N).
  - Never needed for JUMP.
- Destination extension is needed only when TWO-OP and ad==1.
- Word order: opcode, then source extension, then destination extension.
- Transitions:
  - OPW -> SEXT if source extension needed, else DEXT if destination extension needed, else IDLE.
  - SEXT -> DEXT if destination extension needed, else IDLE.
  - DEXT -> IDLE.
  - ERR -> IDLE.
- Outputs:
  - pmem_wen=1 exactly in OPW, SEXT and DEXT.
  - pmem_din carries the word for the current state.
  - pmem_addr carries the current address.
  - Address increments by 1 after each write and wraps from 2^PMEM_AW-1 to 0.
- done=1 in the cycle of the final write.
- err=1 for one cycle in ERR. No write occurs and the address is unchanged.
- Latency: the opcode write is one cycle after accept. An N-word instruction occupies N+1 cycles from accept to the next possible accept.
- words_total increments on every write and wraps modulo 2^32.

Decomposition:
- Package pu_msp430_inst_encoder_pkg contains:
  - class enum (SIG/JUMP/TWO/ILL);
  - FSM state enum;
  - SIG-OP prefix constant 6'b000100 and JUMP prefix constant 3'b001;
  - functions need_src_ext() and need_dst_ext().
- Sub-module pu_msp430_inst_pack: combinational packer.
  - Inputs: latched descriptor.
  - Outputs: opcode word, src_ext_en, dst_ext_en, illegal.
  - The top level holds the FSM, address counter and handshake.

Test Plan:
- MOV r4,r5 (class2 op4 src4 as0 dst5 ad0) -> one write 0x4405 @0x000 with done; words_total=1.
- MOV #0x1234,&0x0200 (op4 src0 as3 dst2 ad1) -> 0x40B2@0x000, 0x1234@0x001, 0x0200@0x002 in three consecutive cycles; done on the third; desc_ready back high the next cycle.
- JMP -1 (class1 op7 joff 0x3FF) -> 0x3FFF, single word. PUSH.B @r6+ -> 0x1276, single word. CALL #0xF000 -> 0x12B0 then 0xF000.
- Illegal class2 op2, then class0 op7 -> err pulse each; pmem_wen stays 0; address unchanged; a following legal descriptor writes at the original address.
- PMEM_AW=4, START_ADDR=0xE, three-word instruction -> addresses 0xE, 0xF, 0x0. restart and desc_valid in the same cycle -> descriptor not accepted; address=0xE.
- puc_rst asserted during SEXT of a three-word instruction -> next cycle pmem_wen=0, state IDLE, address=START_ADDR, words_total=0, and no DEXT write occurs.
